// File: rtl/rv32zhinx_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rv32zhinx_issue_buffer
// Brief    : Request FIFO, single-op issue sequencer with abort timer, and
//            one-entry response register between the RV32 core and the
//            Zhinx half-precision FPU datapath.
// Revision : 1.0 - initial release
// ============================================================================

package rv32zhinx_issue_buffer_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    FPU_HALF_ADD  = 3'd0,
    FPU_HALF_SUB  = 3'd1,
    FPU_HALF_MUL  = 3'd2,
    FPU_HALF_DIV  = 3'd3,
    FPU_HALF_MIN  = 3'd4,
    FPU_HALF_MAX  = 3'd5,
    FPU_HALF_SQRT = 3'd6,
    FPU_HALF_CMP  = 3'd7
  } fpu_operation_t;
endpackage

module rv32zhinx_issue_buffer
  import rv32zhinx_issue_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  fpu_operation_t             req_op,
  input  logic [WORD_W-1:0]          req_a,
  input  logic [WORD_W-1:0]          req_b,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       fpu_start,
  output fpu_operation_t             fpu_op,
  output logic [WORD_W-1:0]          fpu_a,
  output logic [WORD_W-1:0]          fpu_b,
  input  logic                       fpu_done,
  input  logic [WORD_W-1:0]          fpu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WORD_W-1:0]          rsp_data,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [TMR_W-1:0]   timer;

  fpu_operation_t     mem_op  [DEPTH];
  logic [WORD_W-1:0]  mem_a   [DEPTH];
  logic [WORD_W-1:0]  mem_b   [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];

  logic fifo_empty;
  logic push;
  logic pop;
  logic done_hit;
  logic timeout_hit;
  logic slot_free;

  assign fifo_empty  = (count == '0);
  assign req_ready   = (count < DEPTH_CNT);
  // A request presented during a flush is dropped even though ready is shown.
  assign push        = req_valid && req_ready && !flush;
  // Done wins over a timeout landing in the same cycle.
  assign done_hit    = (state == ST_ISSUE) && fpu_done;
  assign timeout_hit = (state == ST_ISSUE) && !fpu_done && (timer == TIMER_LAST);
  assign pop         = done_hit || timeout_hit;
  // The response slot is usable if empty or being drained this cycle.
  assign slot_free   = !rsp_valid || rsp_ready;

  // The FPU always sees the head entry; an empty FIFO shows a zeroed ADD.
  assign fpu_op = fifo_empty ? FPU_HALF_ADD : mem_op[rd_ptr];
  assign fpu_a  = fifo_empty ? '0 : mem_a[rd_ptr];
  assign fpu_b  = fifo_empty ? '0 : mem_b[rd_ptr];

  // FIFO storage; contents need no reset because occupancy masks stale data.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_op[wr_ptr]  <= req_op;
      mem_a[wr_ptr]   <= req_a;
      mem_b[wr_ptr]   <= req_b;
      mem_tag[wr_ptr] <= req_tag;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue sequencer, abort timer and response register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      fpu_start <= 1'b0;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      fpu_start <= 1'b0;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && slot_free) begin
            state     <= ST_ISSUE;
            fpu_start <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (pop) begin
            state     <= ST_IDLE;
            fpu_start <= 1'b0;
            timer     <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          fpu_start <= 1'b0;
        end
      endcase

      // Completion reloads the slot; ISSUE is only entered with the slot free.
      if (pop) begin
        rsp_valid <= 1'b1;
        rsp_data  <= done_hit ? fpu_result : '0;
        rsp_tag   <= mem_tag[rd_ptr];
        rsp_err   <= timeout_hit;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32zhinx_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32zhinx_issue_buffer
// Brief    : Self-checking bench for rv32zhinx_issue_buffer: queue-based
//            reference model, per-cycle compare, directed scenarios and a
//            randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rv32zhinx_issue_buffer;
  import rv32zhinx_issue_buffer_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic                CLK = 1'b0;
  logic                RST;
  logic                flush;
  logic                req_valid;
  logic                req_ready;
  fpu_operation_t      req_op;
  logic [WORD_W-1:0]   req_a;
  logic [WORD_W-1:0]   req_b;
  logic [TAG_W-1:0]    req_tag;
  logic                fpu_start;
  fpu_operation_t      fpu_op;
  logic [WORD_W-1:0]   fpu_a;
  logic [WORD_W-1:0]   fpu_b;
  logic                fpu_done = 1'b0;
  logic [WORD_W-1:0]   fpu_result = '0;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORD_W-1:0]   rsp_data;
  logic [TAG_W-1:0]    rsp_tag;
  logic                rsp_err;
  logic [CNT_W-1:0]    count;

  rv32zhinx_issue_buffer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .TAG_W   (TAG_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: ops queue + busy op + response slot ----
  typedef struct {
    fpu_operation_t    op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t              m_q[$];
  ent_t              m_h;
  ent_t              m_e;
  bit                m_busy  = 1'b0;
  int                m_timer = 0;
  bit                m_rv    = 1'b0;
  logic [WORD_W-1:0] m_rd    = '0;
  logic [TAG_W-1:0]  m_rt    = '0;
  bit                m_re    = 1'b0;
  bit                m_acc;
  bit                m_load;

  always @(posedge CLK) begin
    if (RST) begin
      m_q.delete();
      m_busy = 0; m_timer = 0; m_rv = 0; m_rd = '0; m_rt = '0; m_re = 0;
    end else if (flush) begin
      m_q.delete();
      m_busy = 0; m_timer = 0; m_rv = 0; m_re = 0;
    end else begin
      m_acc  = req_valid && (m_q.size() < DEPTH);
      m_load = 0;
      if (m_busy) begin
        if (fpu_done || m_timer == TIMEOUT - 1) begin
          m_h    = m_q.pop_front();
          m_load = 1;
          m_rd   = fpu_done ? fpu_result : '0;
          m_rt   = m_h.tag;
          m_re   = !fpu_done;
          m_busy = 0;
          m_timer = 0;
        end else begin
          m_timer++;
        end
      end else if (m_q.size() != 0 && (!m_rv || rsp_ready)) begin
        m_busy = 1;
      end
      if (m_load) m_rv = 1;
      else if (m_rv && rsp_ready) m_rv = 0;
      if (m_acc) begin
        m_e.op = req_op; m_e.a = req_a; m_e.b = req_b; m_e.tag = req_tag;
        m_q.push_back(m_e);
      end
    end
  end

  // ---------------- per-cycle compare ---------------------------------------
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
      chk("count",     32'(count),     32'(m_q.size()));
      chk("fpu_start", 32'(fpu_start), 32'(m_busy));
      chk("fpu_op",    32'(fpu_op),    m_q.size() != 0 ? 32'(m_q[0].op) : 32'(FPU_HALF_ADD));
      chk("fpu_a",     fpu_a,          m_q.size() != 0 ? m_q[0].a : 32'h0);
      chk("fpu_b",     fpu_b,          m_q.size() != 0 ? m_q[0].b : 32'h0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_data",  rsp_data,       m_rd);
      chk("rsp_tag",   32'(rsp_tag),   32'(m_rt));
      chk("rsp_err",   32'(rsp_err),   32'(m_re));
    end
  end

  // ---------------- FPU responder -------------------------------------------
  bit                rnd_mode   = 1'b0;
  bit                force_done = 1'b0;
  int                fpu_lat    = 0;
  logic [WORD_W-1:0] res_fixed  = '0;

  always @(negedge CLK) begin
    #1;
    if (rnd_mode) begin
      fpu_done   = ($urandom_range(0, 2) == 0);
      fpu_result = $urandom;
    end else begin
      fpu_done   = force_done || (m_busy && fpu_lat >= 0 && m_timer == fpu_lat);
      fpu_result = res_fixed;
    end
  end

  // Present one request and hold it until the buffer takes it.
  task automatic send(input fpu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    bit will;
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    for (int i = 0; i < 200; i++) begin
      will = (m_q.size() < DEPTH);
      @(negedge CLK);
      if (will) begin
        req_valid = 0;
        return;
      end
    end
    chk("send_bound", 32'd1, 32'd0);
    req_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  got;
    int  last;
    int  starts;
    bit  seen;
    bit  will;

    RST = 1; flush = 0; req_valid = 0; req_op = FPU_HALF_ADD;
    req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1;
    repeat (2) @(negedge CLK);
    chk_en = 1;
    RST = 0;

    // ---- single add, combinational FPU ----
    fpu_lat = 0; res_fixed = 32'h0000_4200;
    req_valid = 1; req_op = FPU_HALF_ADD; req_a = 32'h3C00; req_b = 32'h4000; req_tag = 5'd7;
    @(negedge CLK);
    req_valid = 0;
    chk("add_count_n",   32'(count), 32'd1);
    chk("add_start_n",   32'(fpu_start), 32'd0);
    @(negedge CLK);
    chk("add_start_n1",  32'(fpu_start), 32'd1);
    chk("add_fpu_a",     fpu_a, 32'h3C00);
    chk("add_fpu_b",     fpu_b, 32'h4000);
    chk("add_fpu_op",    32'(fpu_op), 32'(FPU_HALF_ADD));
    @(negedge CLK);
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_data",  rsp_data, 32'h0000_4200);
    chk("add_rsp_tag",   32'(rsp_tag), 32'd7);
    chk("add_rsp_err",   32'(rsp_err), 32'd0);
    chk("add_count_end", 32'(count), 32'd0);
    @(negedge CLK);
    chk("add_rsp_taken", 32'(rsp_valid), 32'd0);

    // ---- fill and backpressure ----
    rsp_ready = 0;
    for (int t = 1; t <= 5; t++) send(FPU_HALF_SUB, $urandom, $urandom, TAG_W'(t));
    chk("fill_count",     32'(count), 32'd4);
    chk("fill_req_ready", 32'(req_ready), 32'd0);
    chk("fill_rsp_tag",   32'(rsp_tag), 32'd1);
    chk("fill_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1; req_op = FPU_HALF_MAX; req_a = $urandom; req_b = $urandom; req_tag = 5'd6;
    repeat (2) @(negedge CLK);
    chk("fill_held_count", 32'(count), 32'd4);
    rsp_ready = 1;
    got = 0; last = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      will = req_valid && (m_q.size() < DEPTH);
      if (rsp_valid) begin
        chk("drain_tag", 32'(rsp_tag), 32'(got + 1));
        if (got > 0) chk("drain_gap", 32'(c - last), 32'd2);
        last = c;
        got++;
      end
      @(negedge CLK);
      if (will) req_valid = 0;
    end
    chk("drain_total", 32'(got), 32'd6);
    repeat (2) @(negedge CLK);

    // ---- multi-cycle FPU, done 3 cycles after start ----
    fpu_lat = 3; res_fixed = 32'h0000_ABCD;
    send(FPU_HALF_MUL, 32'h1234, 32'h5678, 5'd9);
    starts = 0; seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin seen = 1; break; end
      if (fpu_start) begin
        starts++;
        chk("mc_fpu_a",  fpu_a, 32'h1234);
        chk("mc_fpu_b",  fpu_b, 32'h5678);
        chk("mc_fpu_op", 32'(fpu_op), 32'(FPU_HALF_MUL));
      end
      @(negedge CLK);
    end
    chk("mc_seen",   32'(seen), 32'd1);
    chk("mc_starts", 32'(starts), 32'd4);
    chk("mc_data",   rsp_data, 32'h0000_ABCD);
    chk("mc_tag",    32'(rsp_tag), 32'd9);
    chk("mc_err",    32'(rsp_err), 32'd0);
    chk("mc_count",  32'(count), 32'd0);
    @(negedge CLK);

    // ---- timeout ----
    fpu_lat = -1; res_fixed = 32'hDEAD_BEEF;
    send(FPU_HALF_SUB, 32'h1111, 32'h2222, 5'd3);
    send(FPU_HALF_DIV, 32'h3333, 32'h4444, 5'd4);
    starts = 0; seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (rsp_valid) begin seen = 1; break; end
      if (fpu_start) starts++;
      @(negedge CLK);
    end
    fpu_lat = 0;
    chk("to_seen",   32'(seen), 32'd1);
    chk("to_starts", 32'(starts), 32'(TIMEOUT));
    chk("to_err",    32'(rsp_err), 32'd1);
    chk("to_data",   rsp_data, 32'h0);
    chk("to_tag",    32'(rsp_tag), 32'd3);
    @(negedge CLK);
    chk("to_next_start", 32'(fpu_start), 32'd1);
    chk("to_next_a",     fpu_a, 32'h3333);
    repeat (3) @(negedge CLK);

    // ---- flush during ISSUE with three queued behind ----
    fpu_lat = -1; rsp_ready = 1;
    for (int t = 10; t <= 13; t++) send(FPU_HALF_ADD, $urandom, $urandom, TAG_W'(t));
    chk("fl_pre_count", 32'(count), 32'd4);
    chk("fl_pre_start", 32'(fpu_start), 32'd1);
    flush = 1; force_done = 1; req_valid = 1; req_tag = 5'd20;
    @(negedge CLK);
    flush = 0; req_valid = 0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_start", 32'(fpu_start), 32'd0);
    chk("fl_rsp",   32'(rsp_valid), 32'd0);
    @(negedge CLK);
    force_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("fl_late_done", 32'(rsp_valid), 32'd0);
    end

    // ---- flush with a held response and a request in the flush cycle ----
    fpu_lat = 0; rsp_ready = 0;
    send(FPU_HALF_MIN, 32'h0055, 32'h00AA, 5'd15);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) begin seen = 1; break; end
      @(negedge CLK);
    end
    chk("flr_held", 32'(seen), 32'd1);
    flush = 1; req_valid = 1; req_tag = 5'd21;
    chk("flr_ready_in_flush", 32'(req_ready), 32'd1);
    @(negedge CLK);
    flush = 0; req_valid = 0;
    chk("flr_rsp",   32'(rsp_valid), 32'd0);
    chk("flr_err",   32'(rsp_err), 32'd0);
    chk("flr_count", 32'(count), 32'd0);
    @(negedge CLK);
    chk("flr_start", 32'(fpu_start), 32'd0);
    rsp_ready = 1;

    // ---- randomized traffic ----
    rnd_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      RST       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 99) == 0);
      req_valid = $urandom_range(0, 1);
      req_op    = fpu_operation_t'($urandom_range(0, 7));
      req_a     = $urandom;
      req_b     = $urandom;
      req_tag   = TAG_W'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      @(negedge CLK);
    end
    RST = 0; flush = 0;

    // ---- reset held two cycles during active traffic ----
    RST = 1; req_valid = 1; rsp_ready = 0;
    repeat (2) @(negedge CLK);
    chk("rst_count",     32'(count), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_start",     32'(fpu_start), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_data",  rsp_data, 32'h0);
    chk("rst_fpu_a",     fpu_a, 32'h0);
    RST = 0; req_valid = 0; rsp_ready = 1; rnd_mode = 0; fpu_lat = 0;
    repeat (4) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
